softreg_responder: RTL and testbench
====================================

SOFTREG_RESPONDER -- requirements
Module: softreg_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of host-writable control registers (power of 2, 1..64).
REQ-002 SHALL have parameter ERR_DATA, default 64'hFFFF_FFFF_FFFF_FFFF, read data returned for unmapped or misaligned addresses.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  app enable; when low, requests are ignored.
REQ-006 SHALL have port softreg_req  input  SoftRegReq  per-app request (valid, isWrite, addr[31:0], data[63:0]), app select already stripped.
REQ-007 SHALL have port softreg_resp  output  SoftRegResp  read response (valid, data[63:0]).
REQ-008 SHALL have port ctrl_regs  output  64 x NUM_REGS  current control register values.
REQ-009 SHALL have port ctrl_wr_pulse  output  NUM_REGS  one-cycle strobe per control register on update.
REQ-010 SHALL have port status_in  input  64 x NUM_REGS  app-driven read-only status values.
REQ-011 SHALL have port event_in  input  1  event pulse; one increment per high cycle.

Function
REQ-012 SHALL accept a request in any cycle with softreg_req.valid=1 and enable=1; no backpressure exists, one request per cycle.
REQ-013 SHALL decode word index w = addr[15:3]; addr[2:0] != 0 SHALL mark the request misaligned, treated as unmapped.
REQ-014 SHALL map: w < NUM_REGS -> control reg w (RW); NUM_REGS <= w < 2*NUM_REGS -> status_in[w-NUM_REGS] (RO); w = 2*NUM_REGS -> event counter (RO, read-to-clear); w = 2*NUM_REGS+1 -> {read_count[31:0], write_count[31:0]} (RO); all else unmapped.
REQ-015 SHALL on accepted write to control reg k: update ctrl_regs[k] at the next edge and assert ctrl_wr_pulse[k] for exactly that one cycle; no response generated.
REQ-016 SHALL silently discard writes to RO or unmapped addresses (no state change, no pulse, no response); write_count still increments.
REQ-017 SHALL produce exactly one response per accepted read, softreg_resp.valid high for one cycle, exactly 1 cycle after the request cycle.
REQ-018 SHALL drive softreg_resp.data = value sampled at the request cycle edge (control regs pre-write, status_in as presented that cycle); unmapped/misaligned -> ERR_DATA.
REQ-019 SHALL return a back-to-back read after write to the same control reg (next cycle) with the new value.
REQ-020 SHALL hold softreg_resp.data at 0 when softreg_resp.valid=0.
REQ-021 SHALL keep a 64-bit event counter incrementing per event_in cycle, saturating at all-ones.
REQ-022 SHALL on read of the event counter return the current value and clear it; if event_in is high that cycle, counter becomes 1 after the edge.
REQ-023 SHALL keep 32-bit wrapping read_count/write_count of accepted reads/writes (including unmapped); a read of the counter word returns values before counting itself.
REQ-024 SHALL, with enable=0, ignore requests entirely: no response, no writes, no counter changes; event counter still counts.

Reset
REQ-025 SHALL, on rst_n low, immediately force softreg_resp.valid=0, data=0, ctrl_regs all 0, ctrl_wr_pulse 0, event counter 0, read_count/write_count 0.
REQ-026 SHALL discard any response pending at reset assertion; first request after rst_n rises is serviced normally.

Verification
REQ-027 SHALL verify (NUM_REGS=8): write addr 0x18 data 0x1234 -> next cycle ctrl_regs[3]=0x1234, ctrl_wr_pulse=8'h08 one cycle, no resp; read 0x18 next cycle -> resp valid +1 cycle, data 0x1234.
REQ-028 SHALL verify: status_in[0]=0xABCD, read addr 0x40 -> data 0xABCD; write 0x40 data 5 -> no pulse, read again 0xABCD.
REQ-029 SHALL verify: 5 event_in pulses, read addr 0x80 -> 5; next read with event_in high same cycle -> 0, following read -> 1.
REQ-030 SHALL verify: write addr 0x19 -> ignored; read 0x19 and read addr 0xA0 -> ERR_DATA; read addr 0x88 after 3 reads and 2 writes -> 64'h0000_0003_0000_0002.
REQ-031 SHALL verify: enable=0, read 0x18 -> no response for 10 cycles, read_count unchanged.
REQ-032 SHALL verify: rst_n low on cycle after read request -> softreg_resp.valid 0 immediately, ctrl_regs 0; after release read 0x18 -> 0.

Source files
------------

// File: rtl/softreg_responder.sv
// softreg_responder: per-app soft register block with control, status and counters.
// Ports: clk, rst_n, enable, softreg_req in; softreg_resp, ctrl_regs, ctrl_wr_pulse out;
//        status_in (read-only app status) and event_in (counted pulse) in.

package softreg_pkg;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

endpackage

module softreg_responder
    import softreg_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  SoftRegReq                  softreg_req,
    output SoftRegResp                 softreg_resp,
    output logic [NUM_REGS-1:0][63:0]  ctrl_regs,
    output logic [NUM_REGS-1:0]        ctrl_wr_pulse,
    input  logic [NUM_REGS-1:0][63:0]  status_in,
    input  logic                       event_in
);

    localparam logic [12:0] EVT_W = 13'(2 * NUM_REGS);
    localparam logic [12:0] CNT_W = 13'(2 * NUM_REGS + 1);

    logic [12:0]         word;
    logic                aligned;
    logic                req_rd;
    logic                req_wr;
    logic                hit_evt;
    logic [NUM_REGS-1:0] wr_sel;
    logic [63:0]         rd_data;

    logic                resp_valid;
    logic [63:0]         resp_data;
    logic [63:0]         evt_cnt;
    logic [31:0]         rd_cnt;
    logic [31:0]         wr_cnt;

    // Upper address bits carry no decode meaning inside an app window.
    logic unused_addr_hi;
    assign unused_addr_hi = ^softreg_req.addr[31:16];

    assign word    = softreg_req.addr[15:3];
    assign aligned = (softreg_req.addr[2:0] == 3'b000);
    assign req_rd  = enable & softreg_req.valid & ~softreg_req.isWrite;
    assign req_wr  = enable & softreg_req.valid & softreg_req.isWrite;
    assign hit_evt = req_rd & aligned & (word == EVT_W);

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wr_sel[k] = req_wr & aligned & (word == 13'(k));
        end
    end

    // Read data is taken from pre-edge state, so a counter or event
    // read reports the value before this request is accounted for.
    always_comb begin
        rd_data = ERR_DATA;
        if (aligned) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (word == 13'(k)) begin
                    rd_data = ctrl_regs[k];
                end
                if (word == 13'(NUM_REGS + k)) begin
                    rd_data = status_in[k];
                end
            end
            if (word == EVT_W) begin
                rd_data = evt_cnt;
            end
            if (word == CNT_W) begin
                rd_data = {rd_cnt, wr_cnt};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            ctrl_regs     <= '0;
            ctrl_wr_pulse <= '0;
            evt_cnt       <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
        end else begin
            resp_valid    <= req_rd;
            resp_data     <= req_rd ? rd_data : 64'd0;
            ctrl_wr_pulse <= wr_sel;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_sel[k]) begin
                    ctrl_regs[k] <= softreg_req.data;
                end
            end
            if (req_rd) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (req_wr) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            // Clear-on-read still keeps an event landing in the same cycle.
            if (hit_evt) begin
                evt_cnt <= {63'd0, event_in};
            end else if (event_in && (evt_cnt != '1)) begin
                evt_cnt <= evt_cnt + 64'd1;
            end
        end
    end

    assign softreg_resp = SoftRegResp'{valid: resp_valid, data: resp_data};

endmodule

// File: tb/tb_softreg_responder.sv
// tb_softreg_responder: random + directed bench with a queue scoreboard.
// A reference model predicts read data; a monitor pops and compares responses.

module tb_softreg_responder;
    import softreg_pkg::*;

    localparam int          N   = 8;
    localparam logic [63:0] ERR = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                event_in = 1'b0;
    SoftRegReq           req;
    SoftRegResp          resp;
    logic [N-1:0][63:0]  ctrl_regs;
    logic [N-1:0][63:0]  status_in;
    logic [N-1:0]        ctrl_wr_pulse;

    always #5 clk = ~clk;

    softreg_responder #(.NUM_REGS(N), .ERR_DATA(ERR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .softreg_req   (req),
        .softreg_resp  (resp),
        .ctrl_regs     (ctrl_regs),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .status_in     (status_in),
        .event_in      (event_in)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];

    logic [63:0] m_ctrl [N];
    logic [63:0] m_evt;
    logic [31:0] m_rd;
    logic [31:0] m_wr;
    logic [N-1:0] m_pulse;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [31:0] a);
        int w;
        w = int'(a[15:3]);
        if (a[2:0] != 3'b000) return ERR;
        if (w < N) return m_ctrl[w];
        if (w < 2 * N) return status_in[w-N];
        if (w == 2 * N) return m_evt;
        if (w == 2 * N + 1) return {m_rd, m_wr};
        return ERR;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) m_ctrl[k] = '0;
        m_evt = '0;
        m_rd = '0;
        m_wr = '0;
        m_pulse = '0;
        q.delete();
    endtask

    task automatic step(input logic en, input logic vld, input logic wr,
                        input logic [31:0] a, input logic [63:0] d,
                        input logic ev);
        int   w;
        int   bad;
        logic evt_rd;
        enable = en;
        req.valid = vld;
        req.isWrite = wr;
        req.addr = a;
        req.data = d;
        event_in = ev;
        m_pulse = '0;
        evt_rd = 1'b0;
        w = int'(a[15:3]);
        if (en && vld) begin
            if (!wr) begin
                q.push_back(exp_t'{due: cyc + 1, data: m_read(a)});
                m_rd++;
                evt_rd = (a[2:0] == 3'b000) && (w == 2 * N);
            end else begin
                m_wr++;
                if (a[2:0] == 3'b000 && w < N) begin
                    m_ctrl[w] = d;
                    m_pulse[w] = 1'b1;
                end
            end
        end
        if (evt_rd) m_evt = {63'd0, ev};
        else if (ev && m_evt != '1) m_evt++;
        @(posedge clk);
        @(negedge clk);
        chk("wr_pulse", 64'(ctrl_wr_pulse), 64'(m_pulse));
        bad = -1;
        for (int k = 0; k < N; k++) begin
            if (ctrl_regs[k] !== m_ctrl[k]) bad = k;
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL ctrl_regs[%0d]: got %h want %h",
                     bad, ctrl_regs[bad], m_ctrl[bad]);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, a, 64'd0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        step(1'b1, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req.valid = 1'b0;
        event_in = 1'b0;
        model_clear();
        #1;
        chk("rst_resp_valid", 64'(resp.valid), 64'd0);
        chk("rst_resp_data", resp.data, 64'd0);
        chk("rst_ctrl_zero", 64'(ctrl_regs == '0), 64'd1);
        chk("rst_pulse", 64'(ctrl_wr_pulse), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor: decoupled from the driver, keyed on cycle count.
    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n) begin
                exp_v = (q.size() > 0) && (q[0].due == cyc);
                vectors++;
                if (resp.valid !== exp_v) begin
                    miscompares++;
                    $display("FAIL resp_valid cyc=%0d: got %b want %b",
                             cyc, resp.valid, exp_v);
                end
                if (exp_v) begin
                    e = q.pop_front();
                    vectors++;
                    if (resp.data !== e.data) begin
                        miscompares++;
                        $display("FAIL resp_data cyc=%0d: got %h want %h",
                                 cyc, resp.data, e.data);
                    end
                end else begin
                    vectors++;
                    if (resp.data !== 64'd0) begin
                        miscompares++;
                        $display("FAIL idle_data cyc=%0d: got %h want 0",
                                 cyc, resp.data);
                    end
                end
                while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int w;
        req = '0;
        status_in = '0;
        model_clear();
        #3;
        do_reset();

        wr(32'h18, 64'h1234);
        chk("ctrl3_after_wr", ctrl_regs[3], 64'h1234);
        chk("pulse_after_wr", 64'(ctrl_wr_pulse), 64'h08);
        rd(32'h18);
        chk("rd_after_wr", resp.data, 64'h1234);
        chk("pulse_one_cycle", 64'(ctrl_wr_pulse), 64'd0);

        status_in[0] = 64'hABCD;
        rd(32'h40);
        chk("status0", resp.data, 64'hABCD);
        wr(32'h40, 64'd5);
        chk("ro_wr_nopulse", 64'(ctrl_wr_pulse), 64'd0);
        rd(32'h40);
        chk("status0_again", resp.data, 64'hABCD);

        repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h80, 64'd0, 1'b0);
        chk("evt_5", resp.data, 64'd5);
        step(1'b1, 1'b1, 1'b0, 32'h80, 64'd0, 1'b1);
        chk("evt_cleared", resp.data, 64'd0);
        step(1'b1, 1'b1, 1'b0, 32'h80, 64'd0, 1'b0);
        chk("evt_same_cycle", resp.data, 64'd1);
        idle();

        do_reset();
        wr(32'h19, 64'hDEAD);
        chk("misaligned_wr", ctrl_regs[3], 64'd0);
        rd(32'h19);
        chk("misaligned_rd", resp.data, ERR);
        rd(32'hA0);
        chk("unmapped_rd", resp.data, ERR);
        wr(32'h18, 64'h77);
        rd(32'h18);
        rd(32'h88);
        chk("counts_3r_2w", resp.data, 64'h0000_0003_0000_0002);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h18, 64'd0, 1'b0);
            chk("disabled_noresp", 64'(resp.valid), 64'd0);
        end
        step(1'b0, 1'b1, 1'b1, 32'h18, 64'h55, 1'b0);
        chk("disabled_nowr", ctrl_regs[3], 64'h77);
        rd(32'h88);
        chk("counts_after_dis", resp.data, 64'h0000_0004_0000_0002);

        rd(32'h18);
        chk("pre_rst_valid", 64'(resp.valid), 64'd1);
        do_reset();
        rd(32'h18);
        chk("post_rst_rd", resp.data, 64'd0);

        // Request in flight when reset hits: it must never answer.
        enable = 1'b1;
        req.valid = 1'b1;
        req.isWrite = 1'b0;
        req.addr = 32'h18;
        #2;
        do_reset();
        idle();
        chk("discarded_resp", 64'(resp.valid), 64'd0);

        repeat (3000) begin
            status_in[$urandom_range(0, N - 1)] = {$urandom, $urandom};
            w = $urandom_range(0, 2 * N + 3);
            a = {16'h0, 13'(w), 3'b000};
            if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                 1'($urandom_range(0, 1)));
        end

        repeat (3) idle();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
